// File: rtl/watch_pkg.sv
// Shared definitions for the stopwatch: state codes for the control FSM and
// the default system clock frequency used by both control and datapath.
package watch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int DEFAULT_CLK_HZ = 100_000_000;

endpackage

// File: rtl/btn_debounce.sv
// One push-button cleaner: 2-flop synchronizer, sample history, debounced level
// and a single-cycle pulse on each rising edge of that level.
module btn_debounce #(
  parameter int STABLE_N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic sample_tick_i,
  output logic event_o
);

  logic                sync1_q, sync2_q;
  logic [STABLE_N-1:0] hist_q, hist_d;
  logic                level_q, level_d;
  logic                level_prev_q;
  logic                event_q;

  // The level only moves when the whole window agrees; mixed histories hold it.
  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    if (sample_tick_i) begin
      hist_d = {hist_q[STABLE_N-2:0], sync2_q};
      if (&hist_d) begin
        level_d = 1'b1;
      end else if (~|hist_d) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      event_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      hist_q       <= hist_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      event_q      <= level_q & ~level_prev_q;
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: debounces three buttons and sequences
// run/stop/clear, driving the datapath enable/clear/change and a state code.
module stopwatch_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ    = DEFAULT_CLK_HZ,
  parameter int SAMPLE_HZ = 1000,
  parameter int STABLE_N  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_clear,
  input  logic               btn_mode,
  output logic               enable,
  output logic               clear,
  output logic               change,
  output logic [STATE_W-1:0] state
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_q, div_d;
  logic             sample_tick;
  logic             ev_run, ev_clear, ev_mode;
  state_e           state_q;
  logic             enable_q, clear_q, change_q;

  assign sample_tick = (div_q == CNT_LAST);
  assign div_d       = sample_tick ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  btn_debounce #(.STABLE_N(STABLE_N)) u_db_run (
    .clk           (clk),
    .reset         (reset),
    .btn_i         (btn_run),
    .sample_tick_i (sample_tick),
    .event_o       (ev_run)
  );

  btn_debounce #(.STABLE_N(STABLE_N)) u_db_clear (
    .clk           (clk),
    .reset         (reset),
    .btn_i         (btn_clear),
    .sample_tick_i (sample_tick),
    .event_o       (ev_clear)
  );

  btn_debounce #(.STABLE_N(STABLE_N)) u_db_mode (
    .clk           (clk),
    .reset         (reset),
    .btn_i         (btn_mode),
    .sample_tick_i (sample_tick),
    .event_o       (ev_mode)
  );

  // Outputs are registered alongside the state so they always match state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STOP;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      case (state_q)
        STOP: begin
          if (ev_run) begin
            state_q  <= RUN;
            enable_q <= 1'b1;
            clear_q  <= 1'b0;
          end else if (ev_clear) begin
            state_q  <= CLEAR;
            enable_q <= 1'b0;
            clear_q  <= 1'b1;
          end else begin
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
          end
        end
        RUN: begin
          clear_q <= 1'b0;
          if (ev_run) begin
            state_q  <= STOP;
            enable_q <= 1'b0;
          end else begin
            enable_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q  <= STOP;
          enable_q <= 1'b0;
          clear_q  <= 1'b0;
        end
        default: begin
          state_q  <= STOP;
          enable_q <= 1'b0;
          clear_q  <= 1'b0;
        end
      endcase
    end
  end

  // Mode toggling bypasses the FSM entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      change_q <= 1'b0;
    end else begin
      change_q <= ev_mode;
    end
  end

  assign enable = enable_q;
  assign clear  = clear_q;
  assign change = change_q;
  assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: each expected output vector
// {change, clear, enable, state} is queued when stimulus is driven and popped
// whenever the observed vector changes.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_mode = 1'b0;
  logic       enable, clear, change;
  logic [1:0] state;

  logic [4:0] exp_q[$];
  logic [4:0] exp_cur = 5'b00000;
  logic [4:0] prev_v = 5'b00000;
  int         tests = 0;
  int         fails = 0;

  localparam logic [4:0] V_STOP  = 5'b00000;
  localparam logic [4:0] V_RUN   = 5'b00101;
  localparam logic [4:0] V_CLR   = 5'b01010;
  localparam logic [4:0] V_MODES = 5'b10000;
  localparam logic [4:0] V_MODER = 5'b10101;

  stopwatch_ctrl #(
    .CLK_HZ    (1000),
    .SAMPLE_HZ (100),
    .STABLE_N  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .btn_mode  (btn_mode),
    .enable    (enable),
    .clear     (clear),
    .change    (change),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Monitor: every change of the output vector must match the next expectation,
  // and clear/change pulses may last only one cycle.
  always @(negedge clk) begin
    logic [4:0] cur;
    logic [4:0] e;
    cur = {change, clear, enable, state};
    if (cur !== prev_v) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_change observed=%b required=%b", cur, prev_v);
      end else begin
        e = exp_q.pop_front();
        assert (cur === e) else begin
          fails++;
          $error("FAIL output_seq observed=%b required=%b", cur, e);
        end
      end
    end
    if (prev_v[4]) begin
      tests++;
      assert (cur[4] === 1'b0) else begin
        fails++;
        $error("FAIL change_width observed=%b required=0", cur[4]);
      end
    end
    if (prev_v[3]) begin
      tests++;
      assert (cur[3] === 1'b0) else begin
        fails++;
        $error("FAIL clear_width observed=%b required=0", cur[3]);
      end
    end
    prev_v = cur;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] m, input int hold_n, input int gap_n);
    {btn_mode, btn_clear, btn_run} = m;
    wait_clks(hold_n);
    {btn_mode, btn_clear, btn_run} = 3'b000;
    wait_clks(gap_n);
  endtask

  task automatic expect_v(input logic [4:0] v);
    exp_q.push_back(v);
    if (!v[4]) exp_cur = v;
  endtask

  task automatic check_idle(input string tag);
    logic [4:0] cur;
    @(negedge clk);
    #1;
    cur = {change, clear, enable, state};
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s_pending observed=%0d required=0", tag, exp_q.size());
    end
    tests++;
    assert (cur === exp_cur) else begin
      fails++;
      $error("FAIL %s_outputs observed=%b required=%b", tag, cur, exp_cur);
    end
  endtask

  initial begin
    wait_clks(3);
    reset = 1'b0;
    check_idle("reset");
    wait_clks(200);
    check_idle("idle");

    // Long hold: one event only.
    expect_v(V_RUN);
    press(3'b001, 100, 80);
    check_idle("hold_run");
    expect_v(V_STOP);
    press(3'b001, 60, 80);
    check_idle("back_stop");

    // Bouncing input never sees 4 consecutive high samples.
    for (int i = 0; i < 60; i++) begin
      btn_run = ((i / 7) % 2) == 0;
      wait_clks(1);
    end
    btn_run = 1'b0;
    wait_clks(80);
    check_idle("bounce");
    expect_v(V_RUN);
    press(3'b001, 60, 80);
    check_idle("after_bounce");

    // Clear ignored in RUN, then stop and clear.
    press(3'b010, 60, 80);
    check_idle("clear_in_run");
    expect_v(V_STOP);
    press(3'b001, 60, 80);
    check_idle("stop");
    expect_v(V_CLR);
    expect_v(V_STOP);
    press(3'b010, 60, 80);
    check_idle("clear");

    // Simultaneous run+clear in STOP: run wins.
    expect_v(V_RUN);
    press(3'b011, 60, 80);
    check_idle("run_wins");

    // Mode in RUN and STOP.
    expect_v(V_MODER);
    expect_v(V_RUN);
    press(3'b100, 60, 80);
    check_idle("mode_run");
    expect_v(V_STOP);
    press(3'b001, 60, 80);
    expect_v(V_MODES);
    expect_v(V_STOP);
    press(3'b100, 60, 80);
    check_idle("mode_stop");

    // Reset mid-press in RUN, button held through release must re-qualify.
    expect_v(V_RUN);
    press(3'b001, 60, 80);
    check_idle("pre_reset");
    btn_run = 1'b1;
    wait_clks(25);
    expect_v(V_STOP);
    reset = 1'b1;
    wait_clks(3);
    check_idle("in_reset");
    reset = 1'b0;
    wait_clks(35);
    check_idle("requalify");
    expect_v(V_RUN);
    wait_clks(40);
    btn_run = 1'b0;
    wait_clks(80);
    check_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
